// File: rtl/fsk_tx_sequencer.sv
// Queues Hamming codewords and serialises each one as sync + 11 data bits (MSB first) + idle gap.
// One bit per BIT_CYCLES clocks; push-to-first-sync-bit is 2 clocks; ready drops when the queue is full.
module fsk_tx_sequencer #(
   parameter int         BIT_CYCLES = 4,
   parameter int         SYNC_LEN   = 4,
   parameter logic [7:0] SYNC_PAT   = 8'b0000_1101,
   parameter int         DEPTH      = 4,
   parameter int         GAP_BITS   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] code,
   input  logic        send,
   output logic        tx_bit,
   output logic        tx_en,
   output logic        bit_strobe,
   output logic        frame_done,
   output logic        busy,
   output logic        ready,
   output logic        overflow
);
   localparam int CW      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int PW      = $clog2(DEPTH);
   localparam int GAP_CYC = (GAP_BITS > 0) ? GAP_BITS * BIT_CYCLES : 1;
   localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
   localparam logic [3:0]    SYNC_FIRST = 4'(SYNC_LEN - 1);
   localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, SYNC, DATA, GAP} state_t;

   state_t        state_q;
   logic [CW-1:0] cyc_q;
   logic [3:0]    idx_q;
   logic [10:0]   sr_q;
   logic [GW-1:0] gap_q;
   logic          tx_bit_q;
   logic          tx_en_q;
   logic          strobe_q;
   logic          done_q;

   logic          send_q;
   logic          ovf_q;
   logic [10:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [PW:0]   cnt_q;

   logic          push_req;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          cyc_wrap;
   logic [2:0]    sync_nxt;

   assign push_req = send & ~send_q;
   assign pop      = (state_q == LOAD);
   assign full     = (cnt_q == FULL_CNT);
   // A full queue still takes a word when the head leaves on the same edge.
   assign push_ok  = push_req & (~full | pop);
   assign cyc_wrap = (cyc_q == CYC_LAST);
   assign sync_nxt = idx_q[2:0] - 3'd1;

   assign tx_bit     = tx_bit_q;
   assign tx_en      = tx_en_q;
   assign bit_strobe = strobe_q;
   assign frame_done = done_q;
   assign busy       = (state_q != IDLE);
   assign ready      = ~full;
   assign overflow   = ovf_q;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_q] <= code;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         send_q <= 1'b0;
         ovf_q  <= 1'b0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
      end else begin
         send_q <= send;
         if (push_ok) begin
            wr_q <= wr_q + PW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + PW'(1);
         end
         if (push_req && full && !pop) begin
            ovf_q <= 1'b1;
         end
         if (push_ok && !pop) begin
            cnt_q <= cnt_q + (PW+1)'(1);
         end else if (pop && !push_ok) begin
            cnt_q <= cnt_q - (PW+1)'(1);
         end
      end
   end

   // Outputs are registered: each branch sets them for the cycle the next state covers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         idx_q    <= '0;
         sr_q     <= '0;
         gap_q    <= '0;
         tx_en_q  <= 1'b0;
         tx_bit_q <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_en_q  <= 1'b0;
               tx_bit_q <= 1'b0;
               if (cnt_q != '0) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               sr_q     <= mem_q[rd_q];
               idx_q    <= SYNC_FIRST;
               cyc_q    <= '0;
               state_q  <= SYNC;
               tx_en_q  <= 1'b1;
               tx_bit_q <= SYNC_PAT[SYNC_LEN-1];
               strobe_q <= 1'b1;
            end
            SYNC: begin
               if (cyc_wrap) begin
                  cyc_q    <= '0;
                  strobe_q <= 1'b1;
                  if (idx_q == 4'd0) begin
                     state_q  <= DATA;
                     idx_q    <= 4'd10;
                     tx_bit_q <= sr_q[10];
                  end else begin
                     idx_q    <= idx_q - 4'd1;
                     tx_bit_q <= SYNC_PAT[sync_nxt];
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end
            DATA: begin
               if (cyc_wrap) begin
                  cyc_q <= '0;
                  if (idx_q == 4'd0) begin
                     tx_en_q  <= 1'b0;
                     tx_bit_q <= 1'b0;
                     if (GAP_BITS > 0) begin
                        state_q <= GAP;
                        gap_q   <= '0;
                     end else if (cnt_q != '0) begin
                        state_q <= LOAD;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     sr_q     <= {sr_q[9:0], 1'b0};
                     idx_q    <= idx_q - 4'd1;
                     tx_bit_q <= sr_q[9];
                     strobe_q <= 1'b1;
                     done_q   <= (BIT_CYCLES == 1) && (idx_q == 4'd1);
                  end
               end else begin
                  cyc_q  <= cyc_q + CW'(1);
                  done_q <= (idx_q == 4'd0) && ((cyc_q + CW'(1)) == CYC_LAST);
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  state_q <= (cnt_q != '0) ? LOAD : IDLE;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fsk_tx_sequencer.sv
// Bench for fsk_tx_sequencer: a frame-schedule model predicts every output on every cycle,
// while each scenario task also checks its own directed expectations.
module tb_fsk_tx_sequencer;
   localparam int BC     = 4;
   localparam int SL     = 4;
   localparam int DEPTH  = 4;
   localparam int GB     = 1;
   localparam int FLEN   = (SL + 11) * BC;
   localparam int PERIOD = FLEN + GB * BC + 1;

   logic        clk;
   logic        reset;
   logic        send;
   logic [10:0] code;
   logic        tx_bit, tx_en, bit_strobe, frame_done, busy, ready, overflow;

   fsk_tx_sequencer dut (
      .clk(clk), .reset(reset), .code(code), .send(send),
      .tx_bit(tx_bit), .tx_en(tx_en), .bit_strobe(bit_strobe), .frame_done(frame_done),
      .busy(busy), .ready(ready), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [7:0]  sync_pat = 8'b0000_1101;
   logic [3:0]  sync4;
   assign sync4 = sync_pat[3:0];

   // Model: each accepted word starts its first sync bit at max(push+2, previous start+PERIOD);
   // the head leaves the queue on that same edge.
   int          fr_start[$];
   logic [10:0] fr_code[$];
   int          occ = 0;
   int          next_pop = 0;
   int          last_start = -1000;
   bit          m_ovf = 0;
   bit          m_ready = 1;
   bit          send_prev = 0;

   always @(posedge clk) begin
      bit pop_now;
      int st;
      cyc = cyc + 1;
      if (!reset) begin
         fr_start.delete(); fr_code.delete();
         occ = 0; next_pop = 0; last_start = -1000; m_ovf = 0; send_prev = 0;
      end else begin
         pop_now = (next_pop < fr_start.size()) && (fr_start[next_pop] == cyc);
         if (send && !send_prev) begin
            if (occ == DEPTH && !pop_now) begin
               m_ovf = 1;
            end else begin
               st = (cyc + 2 > last_start + PERIOD) ? cyc + 2 : last_start + PERIOD;
               fr_start.push_back(st);
               fr_code.push_back(code);
               last_start = st;
               occ++;
            end
         end
         if (pop_now) begin
            occ--;
            next_pop++;
         end
         send_prev = send;
      end
      m_ready = (occ != DEPTH);
   end

   // {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow} expected after edge e
   function automatic logic [6:0] exp_at(int e);
      logic en, b, stb, fd, bsy;
      int off, bi;
      en = 0; b = 0; stb = 0; fd = 0; bsy = 0;
      for (int k = 0; k < fr_start.size(); k++) begin
         off = e - fr_start[k];
         if (off >= -1 && off <= FLEN + GB * BC - 1) bsy = 1;
         if (off >= 0 && off < FLEN) begin
            bi  = off / BC;
            en  = 1;
            stb = (off % BC) == 0;
            fd  = (off == FLEN - 1);
            b   = (bi < SL) ? sync_pat[SL-1-bi] : fr_code[k][10-(bi-SL)];
         end
      end
      return {en, b, stb, fd, bsy, m_ready, m_ovf};
   endfunction

   // Received-frame collector (no checking here)
   logic [14:0] rx_words[$];
   logic [14:0] rx_acc = '0;
   int          rx_n = 0;
   always @(negedge clk) begin
      if (!reset) begin
         rx_n = 0;
      end else if (tx_en && bit_strobe) begin
         rx_acc = {rx_acc[13:0], tx_bit};
         rx_n++;
         if (rx_n == 15) begin
            rx_words.push_back(rx_acc);
            rx_n = 0;
         end
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      send  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rx_words.delete();
   endtask

   task automatic test_reset();
      logic [6:0] got;
      @(negedge clk);
      got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
      compared++;
      if (got !== 7'b0000010) begin
         mismatched++; $display("FAIL reset_state got=%b exp=%b", got, 7'b0000010);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
      compared++;
      if (got !== 7'b0000010) begin
         mismatched++; $display("FAIL idle_after_reset got=%b exp=%b", got, 7'b0000010);
      end
   endtask

   task automatic test_single();
      logic [6:0] got, expv;
      int push_e, first_en, n_en, n_stb, fd_at;
      first_en = -1; n_en = 0; n_stb = 0; fd_at = -1;
      do_reset();
      @(negedge clk);
      code = 11'h5A3; send = 1'b1; push_e = cyc + 1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (i == 0) send = 1'b0;
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL single_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
         if (tx_en) begin
            n_en++;
            if (first_en < 0) first_en = cyc;
         end
         if (bit_strobe) n_stb++;
         if (frame_done) fd_at = n_en;
         if (cyc == push_e + 65) begin
            compared++;
            if (busy !== 1'b1) begin mismatched++; $display("FAIL single_gap_busy got=%b exp=1", busy); end
         end
         if (cyc == push_e + 66) begin
            compared++;
            if (busy !== 1'b0) begin mismatched++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
         end
      end
      compared++;
      if (first_en != push_e + 2) begin
         mismatched++; $display("FAIL single_latency got=%0d exp=%0d", first_en - push_e, 2);
      end
      compared++;
      if (n_en != 60) begin mismatched++; $display("FAIL single_tx_en_len got=%0d exp=60", n_en); end
      compared++;
      if (n_stb != 15) begin mismatched++; $display("FAIL single_strobes got=%0d exp=15", n_stb); end
      compared++;
      if (fd_at != 60) begin mismatched++; $display("FAIL single_frame_done got=%0d exp=60", fd_at); end
      compared++;
      if (rx_words.size() != 1 || rx_words[0] !== 15'b1101_1011_0100_011) begin
         mismatched++;
         $display("FAIL single_stream got_n=%0d got=%b exp=%b", rx_words.size(),
                  (rx_words.size() > 0) ? rx_words[0] : 15'h0, 15'b1101_1011_0100_011);
      end
   endtask

   task automatic test_held_send();
      logic [6:0] got, expv;
      int n_fd;
      n_fd = 0;
      do_reset();
      @(negedge clk);
      code = 11'h7FF; send = 1'b1;
      for (int i = 0; i < 95; i++) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL held_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
         if (frame_done) n_fd++;
         send = (i < 19);
         code = 11'($urandom);
      end
      compared++;
      if (n_fd != 1) begin mismatched++; $display("FAIL held_frames got=%0d exp=1", n_fd); end
      compared++;
      if (overflow !== 1'b0) begin mismatched++; $display("FAIL held_overflow got=%b exp=0", overflow); end
      compared++;
      if (rx_words.size() != 1 || rx_words[0] !== {sync4, 11'h7FF}) begin
         mismatched++; $display("FAIL held_word got_n=%0d exp_n=1", rx_words.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] got, expv;
      int runs[$];
      int low_run, busy_falls;
      bit seen, en_prev, busy_prev;
      low_run = 0; busy_falls = 0; seen = 0; en_prev = 0; busy_prev = 0;
      do_reset();
      for (int i = 0; i < 212; i++) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL b2b_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
         if (tx_en && !en_prev && seen) begin runs.push_back(low_run); low_run = 0; end
         if (tx_en) seen = 1;
         else if (seen) low_run++;
         if (busy_prev && !busy) busy_falls++;
         en_prev = tx_en; busy_prev = busy;
         send = (i == 0 || i == 2 || i == 4);
         code = 11'(i / 2 + 1);
      end
      compared++;
      if (runs.size() != 2 || runs[0] != 5 || runs[1] != 5) begin
         mismatched++; $display("FAIL b2b_gap got_n=%0d first=%0d exp=2 runs of 5", runs.size(),
                                (runs.size() > 0) ? runs[0] : -1);
      end
      compared++;
      if (busy_falls != 1) begin mismatched++; $display("FAIL b2b_idle_between got=%0d exp=1", busy_falls); end
      compared++;
      if (rx_words.size() != 3 || rx_words[0] !== {sync4, 11'h001} || rx_words[1] !== {sync4, 11'h002}
          || rx_words[2] !== {sync4, 11'h003}) begin
         mismatched++; $display("FAIL b2b_order got_n=%0d exp_n=3", rx_words.size());
      end
   endtask

   task automatic test_overflow();
      logic [6:0] got, expv;
      logic [10:0] w[6];
      int t;
      bit ok;
      for (int k = 0; k < 6; k++) w[k] = 11'($urandom);
      do_reset();
      t = cyc + 2;
      for (int i = 0; i < 340; i++) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL ovf_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
         if (cyc == t + 6) begin
            compared++;
            if (ready !== 1'b1) begin mismatched++; $display("FAIL ovf_ready3 got=%b exp=1", ready); end
         end
         if (cyc == t + 8) begin
            compared++;
            if (ready !== 1'b0 || overflow !== 1'b0) begin
               mismatched++; $display("FAIL ovf_full got=%b%b exp=00", ready, overflow);
            end
         end
         if (cyc == t + 10) begin
            compared++;
            if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set got=%b exp=1", overflow); end
         end
         send = (i < 12) && (i % 2 == 0);
         if (i < 12) code = w[i/2];
      end
      compared++;
      if (overflow !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
         mismatched++; $display("FAIL ovf_drained got=%b%b%b exp=110", overflow, ready, busy);
      end
      ok = (rx_words.size() == 5);
      for (int k = 0; k < 5 && ok; k++) ok = (rx_words[k] === {sync4, w[k]});
      compared++;
      if (!ok) begin mismatched++; $display("FAIL ovf_words got_n=%0d exp_n=5", rx_words.size()); end
   endtask

   task automatic test_load_edge_push();
      logic [6:0] got, expv;
      logic [10:0] w[6];
      int t;
      bit ok;
      for (int k = 0; k < 6; k++) w[k] = 11'($urandom);
      do_reset();
      t = cyc + 2;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL ledge_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
         if (cyc == t + 66 || cyc == t + 67) begin
            compared++;
            if (ready !== 1'b0 || overflow !== 1'b0) begin
               mismatched++; $display("FAIL ledge_full cyc=%0d got=%b%b exp=00", cyc, ready, overflow);
            end
         end
         send = (i == 0 || i == 4 || i == 6 || i == 8 || i == 10 || i == 67);
         if (i == 0) code = w[0];
         else if (i <= 10) code = w[i/2 - 1];
         else if (i == 67) code = w[5];
      end
      compared++;
      if (overflow !== 1'b0) begin mismatched++; $display("FAIL ledge_overflow got=%b exp=0", overflow); end
      ok = (rx_words.size() == 6);
      for (int k = 0; k < 6 && ok; k++) ok = (rx_words[k] === {sync4, w[k]});
      compared++;
      if (!ok) begin mismatched++; $display("FAIL ledge_words got_n=%0d exp_n=6", rx_words.size()); end
   endtask

   task automatic test_reset_mid_frame();
      logic [6:0] got, expv;
      int s, n_en;
      n_en = 0;
      do_reset();
      @(negedge clk);
      code = 11'h7FF; send = 1'b1; s = cyc + 3;
      @(negedge clk);
      send = 1'b0;
      while (cyc < s + 37) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL rmid_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
      end
      #2 reset = 1'b0;
      #1;
      compared++;
      if ({tx_en, tx_bit, busy, bit_strobe, frame_done, ready} !== 6'b000001) begin
         mismatched++;
         $display("FAIL rmid_async got=%b exp=%b", {tx_en, tx_bit, busy, bit_strobe, frame_done, ready}, 6'b000001);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL rmid_after cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
         if (tx_en || busy) n_en++;
      end
      compared++;
      if (n_en != 0) begin mismatched++; $display("FAIL rmid_resume got=%0d exp=0", n_en); end
   endtask

   task automatic test_random();
      logic [6:0] got, expv;
      int hold, idle;
      bit ok;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         hold = $urandom_range(1, 3);
         idle = $urandom_range(1, 60);
         code = 11'($urandom);
         for (int i = 0; i < hold + idle; i++) begin
            @(negedge clk);
            got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
            expv = exp_at(cyc);
            compared++;
            if (got !== expv) begin
               mismatched++; $display("FAIL rand_cycle cyc=%0d got=%b exp=%b", cyc, got, expv);
            end
            send = (i < hold);
            if (i >= 1) code = 11'($urandom);
         end
      end
      send = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         got = {tx_en, tx_bit, bit_strobe, frame_done, busy, ready, overflow};
         expv = exp_at(cyc);
         compared++;
         if (got !== expv) begin
            mismatched++; $display("FAIL rand_drain cyc=%0d got=%b exp=%b", cyc, got, expv);
         end
      end
      ok = (rx_words.size() == fr_code.size());
      for (int k = 0; k < fr_code.size() && ok; k++) ok = (rx_words[k] === {sync4, fr_code[k]});
      compared++;
      if (!ok) begin
         mismatched++; $display("FAIL rand_words got_n=%0d exp_n=%0d", rx_words.size(), fr_code.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      send  = 1'b0;
      code  = '0;
      #1 reset = 1'b0;
      test_reset();
      test_single();
      test_held_send();
      test_back_to_back();
      test_overflow();
      test_load_edge_push();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
